// File: rtl/blockmem2p_pipe.sv
// Simple dual-port block memory: byte-enabled write port A, pipelined read port B with a valid
// strobe and selectable read-during-write mode, plus an init engine. Optional parity: BLOCKMEM2P_PARITY_EN.
module blockmem2p_pipe #(
    parameter int                    G_MEMWIDTH   = 32,
    parameter int                    G_MEMDEPTH   = 1024,
    parameter int                    G_RDLATENCY  = 2,
    parameter int                    G_RDW_MODE   = 0,
    parameter logic [G_MEMWIDTH-1:0] G_INIT_VALUE = '0,
    localparam int                   G_ADDRWIDTH  = $clog2(G_MEMDEPTH),
    localparam int                   G_WEWIDTH    = ((G_MEMWIDTH-1)/8)+1
) (
    input  logic                   clka,
    input  logic                   resetn,
    input  logic                   ena,
    input  logic [G_WEWIDTH-1:0]   wea,
    input  logic [G_ADDRWIDTH-1:0] addra,
    input  logic [G_MEMWIDTH-1:0]  dina,
    input  logic                   enb,
    input  logic [G_ADDRWIDTH-1:0] addrb,
    output logic [G_MEMWIDTH-1:0]  doutb,
    output logic                   doutb_valid,
    input  logic                   init_req,
    output logic                   init_busy
`ifdef BLOCKMEM2P_PARITY_EN
   ,output logic                   perr
`endif
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [G_ADDRWIDTH-1:0] LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);
    localparam logic [G_ADDRWIDTH:0]   DEPTH_EXT = (G_ADDRWIDTH+1)'(G_MEMDEPTH);

    state_t                   state;
    logic [G_ADDRWIDTH-1:0]   init_cnt;
    logic [G_MEMWIDTH-1:0]    mem [G_MEMDEPTH];

    logic                     wr_go, rd_go, rd_inrange;
    logic [G_MEMWIDTH-1:0]    wr_mask, rd_word;

    logic [G_MEMWIDTH-1:0]    pipe_data [G_RDLATENCY];
    logic [G_RDLATENCY-1:0]   pipe_valid;

`ifdef BLOCKMEM2P_PARITY_EN
    logic [G_WEWIDTH-1:0]     mem_par [G_MEMDEPTH];
    logic [G_WEWIDTH-1:0]     wr_par, rd_par;
    logic                     rd_err;
    logic [G_RDLATENCY-1:0]   pipe_err;

    // Even parity per byte lane; a partial top lane covers only its existing bits.
    function automatic logic [G_WEWIDTH-1:0] lane_parity(input logic [G_MEMWIDTH-1:0] d);
        logic [G_WEWIDTH-1:0] p;
        p = '0;
        for (int j = 0; j < G_MEMWIDTH; j++) p[j/8] = p[j/8] ^ d[j];
        return p;
    endfunction
`endif

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_mask    = '0;
        for (int j = 0; j < G_MEMWIDTH; j++) wr_mask[j] = wea[j/8];
        rd_inrange = {1'b0, addrb} < DEPTH_EXT;
        wr_go      = (state == ST_RUN) && ena && ({1'b0, addra} < DEPTH_EXT);
        rd_go      = (state == ST_RUN) && enb;
        rd_word    = rd_inrange ? mem[addrb] : '0;
        if (G_RDW_MODE == 1 && wr_go && addra == addrb)
            rd_word = (rd_word & ~wr_mask) | (dina & wr_mask);
`ifdef BLOCKMEM2P_PARITY_EN
        wr_par = lane_parity(dina);
        rd_par = rd_inrange ? mem_par[addrb] : '0;
        if (G_RDW_MODE == 1 && wr_go && addra == addrb)
            rd_par = (rd_par & ~wea) | (wr_par & wea);
        rd_err = |(lane_parity(rd_word) ^ rd_par);
`endif
    end

    // NOTE: the array has no reset; only the init engine gives it defined contents.
    always_ff @(posedge clka) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= G_INIT_VALUE;
`ifdef BLOCKMEM2P_PARITY_EN
            mem_par[init_cnt] <= lane_parity(G_INIT_VALUE);
`endif
        end else if (wr_go) begin
            for (int j = 0; j < G_MEMWIDTH; j++)
                if (wr_mask[j]) mem[addra][j] <= dina[j];
`ifdef BLOCKMEM2P_PARITY_EN
            for (int i = 0; i < G_WEWIDTH; i++)
                if (wea[i]) mem_par[addra][i] <= wr_par[i];
`endif
        end
    end

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                        init_cnt  <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state     <= ST_INIT;
                        init_busy <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Stage 0 is the array output register; later stages only load on valid so doutb holds.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < G_RDLATENCY; k++) pipe_data[k] <= '0;
            pipe_valid <= '0;
`ifdef BLOCKMEM2P_PARITY_EN
            pipe_err   <= '0;
`endif
        end else begin
            pipe_valid[0] <= rd_go;
            if (rd_go) pipe_data[0] <= rd_word;
`ifdef BLOCKMEM2P_PARITY_EN
            pipe_err[0] <= rd_go & rd_err;
`endif
            for (int k = 1; k < G_RDLATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
`ifdef BLOCKMEM2P_PARITY_EN
                pipe_err[k] <= pipe_valid[k-1] & pipe_err[k-1];
`endif
            end
        end
    end

    assign doutb       = pipe_data[G_RDLATENCY-1];
    assign doutb_valid = pipe_valid[G_RDLATENCY-1];
`ifdef BLOCKMEM2P_PARITY_EN
    assign perr        = pipe_err[G_RDLATENCY-1];
`endif

endmodule

// File: tb/tb_blockmem2p_pipe.sv
// Bench for blockmem2p_pipe: three instances (latency 2/1/4, RDW old/new/old) share one stimulus
// and are checked every cycle against a word-level memory model, plus literal directed checks.
`timescale 1ns/1ps
module tb_blockmem2p_pipe;

    localparam int          W      = 32;
    localparam int          DEPTH  = 1000;
    localparam int          AW     = 10;
    localparam int          NDUT   = 3;
    localparam logic [31:0] INIT_V = 32'hA5C3_0F96;
    localparam int          LAT  [NDUT] = '{2, 1, 4};
    localparam int          MODE [NDUT] = '{0, 1, 0};

    logic          clka = 1'b0;
    logic          resetn;
    logic          ena, enb, init_req;
    logic [3:0]    wea;
    logic [AW-1:0] addra, addrb;
    logic [W-1:0]  dina;
    logic [W-1:0]  doutb_a [NDUT];
    logic          valid_a [NDUT];
    logic          busy_a  [NDUT];
`ifdef BLOCKMEM2P_PARITY_EN
    logic          perr_a  [NDUT];
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit compare_en = 1'b0;

    // Behavioural model: the word array, remaining init cycles, and per-instance due-slots.
    logic [W-1:0] ref_mem [DEPTH];
    bit           bad     [DEPTH];
    int           busy_left;
    int           cyc = 0;
    int           cmp_slot;
    bit           exp_v  [NDUT][8];
    logic [W-1:0] exp_d  [NDUT][8];
    bit           exp_pe [NDUT][8];
    logic [W-1:0] hold_d [NDUT];

    always #5 clka = ~clka;

    blockmem2p_pipe #(.G_MEMWIDTH(W), .G_MEMDEPTH(DEPTH), .G_RDLATENCY(2), .G_RDW_MODE(0),
                      .G_INIT_VALUE(INIT_V)) dut0 (
        .clka(clka), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_a[0]), .doutb_valid(valid_a[0]),
        .init_req(init_req), .init_busy(busy_a[0])
`ifdef BLOCKMEM2P_PARITY_EN
       ,.perr(perr_a[0])
`endif
    );

    blockmem2p_pipe #(.G_MEMWIDTH(W), .G_MEMDEPTH(DEPTH), .G_RDLATENCY(1), .G_RDW_MODE(1),
                      .G_INIT_VALUE(INIT_V)) dut1 (
        .clka(clka), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_a[1]), .doutb_valid(valid_a[1]),
        .init_req(init_req), .init_busy(busy_a[1])
`ifdef BLOCKMEM2P_PARITY_EN
       ,.perr(perr_a[1])
`endif
    );

    blockmem2p_pipe #(.G_MEMWIDTH(W), .G_MEMDEPTH(DEPTH), .G_RDLATENCY(4), .G_RDW_MODE(0),
                      .G_INIT_VALUE(INIT_V)) dut2 (
        .clka(clka), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_a[2]), .doutb_valid(valid_a[2]),
        .init_req(init_req), .init_busy(busy_a[2])
`ifdef BLOCKMEM2P_PARITY_EN
       ,.perr(perr_a[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    always @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            busy_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) begin ref_mem[a] = INIT_V; bad[a] = 1'b0; end
            for (int d = 0; d < NDUT; d++) begin
                hold_d[d] = '0;
                for (int s = 0; s < 8; s++) exp_v[d][s] = 1'b0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < NDUT; d++) exp_v[d][(cyc + 7) % 8] = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (enb) begin
                    for (int d = 0; d < NDUT; d++) begin
                        int          slot;
                        logic [31:0] v;
                        slot = (cyc + LAT[d] - 1) % 8;
                        v = (int'(addrb) < DEPTH) ? ref_mem[addrb] : 32'h0;
                        if (MODE[d] == 1 && ena && addra == addrb && int'(addra) < DEPTH)
                            v = (v & ~byte_mask(wea)) | (dina & byte_mask(wea));
                        exp_v[d][slot]  = 1'b1;
                        exp_d[d][slot]  = v;
                        exp_pe[d][slot] = (d == 0) && (int'(addrb) < DEPTH) && bad[addrb];
                    end
                end
                if (ena && int'(addra) < DEPTH) begin
                    ref_mem[addra] = (ref_mem[addra] & ~byte_mask(wea)) | (dina & byte_mask(wea));
                    if (wea[1]) bad[addra] = 1'b0;
                end
                if (init_req) begin
                    busy_left = DEPTH;
                    for (int a = 0; a < DEPTH; a++) begin ref_mem[a] = INIT_V; bad[a] = 1'b0; end
                end
            end
        end
    end

    always @(negedge clka) begin
        if (compare_en) begin
            cmp_slot = cyc % 8;
            for (int d = 0; d < NDUT; d++) begin
                bit ev;
                ev = resetn && exp_v[d][cmp_slot];
                if (ev) hold_d[d] = exp_d[d][cmp_slot];
                check($sformatf("dut%0d valid", d), 32'(valid_a[d]), 32'(ev));
                check($sformatf("dut%0d doutb", d), doutb_a[d], hold_d[d]);
                check($sformatf("dut%0d busy", d), 32'(busy_a[d]), 32'(busy_left > 0));
`ifdef BLOCKMEM2P_PARITY_EN
                check($sformatf("dut%0d perr", d), 32'(perr_a[d]), 32'(ev && exp_pe[d][cmp_slot]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; init_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] we);
        ena = 1'b1; addra = AW'(a); dina = d; wea = we;
        tick();
        ena = 1'b0;
    endtask

    // Single read; checks the latency-1 and latency-2 instances at their exact cycles and the strobe width.
    task automatic read_lat(input int a, input logic [31:0] exp0, input logic [31:0] exp1);
        enb = 1'b1; addrb = AW'(a);
        tick();
        enb = 1'b0;
        check("lat1 valid", 32'(valid_a[1]), 32'd1);
        check("lat1 data", doutb_a[1], exp1);
        check("lat2 early valid", 32'(valid_a[0]), 32'd0);
        tick();
        check("lat2 valid", 32'(valid_a[0]), 32'd1);
        check("lat2 data", doutb_a[0], exp0);
        tick();
        check("lat2 strobe width", 32'(valid_a[0]), 32'd0);
        check("lat2 hold", doutb_a[0], exp0);
        repeat (3) tick();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_a[0] && n < DEPTH + 50);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return AW'($urandom_range(DEPTH, 1023));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        int n;
        int seen [NDUT];
        resetn = 1'b0; idle(); wea = '0; addra = '0; addrb = '0; dina = '0;
        repeat (3) tick();
        check("reset doutb", doutb_a[0], 32'h0);
        check("reset valid", 32'(valid_a[0]), 32'd0);
        check("reset busy", 32'(busy_a[0]), 32'd1);
        compare_en = 1'b1;
        resetn = 1'b1;
        wait_init(n);
        check("init busy cycles", n, DEPTH);

        wr(5, 32'hDEAD_BEEF, 4'hF);
        wr(5, 32'h0000_1100, 4'h2);
        read_lat(5, 32'hDEAD_11EF, 32'hDEAD_11EF);

        wr(7, 32'h1111_1111, 4'hF);
        ena = 1'b1; addra = 7; dina = 32'h2222_2222; wea = 4'h3; enb = 1'b1; addrb = 7;
        tick();
        idle();
        check("rdw new data", doutb_a[1], 32'h1111_2222);
        tick();
        check("rdw old data", doutb_a[0], 32'h1111_1111);
        repeat (4) tick();
        read_lat(7, 32'h1111_2222, 32'h1111_2222);

        wr(1005, 32'hFFFF_FFFF, 4'hF);
        read_lat(1005, 32'h0, 32'h0);

        for (int a = 0; a < 16; a++) wr(a, 32'(a), 4'hF);
        for (int d = 0; d < NDUT; d++) seen[d] = 0;
        for (int t = 0; t < 24; t++) begin
            if (t < 16) begin enb = 1'b1; addrb = AW'(t); end else enb = 1'b0;
            tick();
            for (int d = 0; d < NDUT; d++)
                if (valid_a[d]) begin
                    check($sformatf("stream dut%0d data", d), doutb_a[d], 32'(seen[d]));
                    seen[d]++;
                end
        end
        for (int d = 0; d < NDUT; d++) check($sformatf("stream dut%0d count", d), seen[d], 16);

        for (int i = 0; i < 2500; i++) begin
            ena = 1'($urandom_range(0, 1)); wea = 4'($urandom); dina = $urandom; addra = rand_addr();
            enb = ($urandom_range(0, 9) < 6);
            addrb = ($urandom_range(0, 3) == 0) ? addra : rand_addr();
            init_req = (i == 1200) || ($urandom_range(0, 1499) == 0);
            tick();
        end
        idle();
        wait_init(n);
        repeat (6) tick();

        wr(5, 32'h0BAD_F00D, 4'hF);
        enb = 1'b1; addrb = 5;
        tick();
        enb = 1'b0; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("in-flight valid", 32'(valid_a[0]), 32'd1);
        check("in-flight data", doutb_a[0], 32'h0BAD_F00D);
        for (int i = 0; i < 20; i++) begin
            ena = 1'b1; wea = 4'hF; dina = $urandom; addra = AW'(i); enb = 1'b1; addrb = AW'(i);
            tick();
        end
        idle();
        wait_init(n);
        check("reinit busy cycles", n, DEPTH - 20);
        for (int a = 0; a < DEPTH; a++) begin enb = 1'b1; addrb = AW'(a); tick(); end
        idle();
        repeat (6) tick();
        read_lat(5, INIT_V, INIT_V);

        init_req = 1'b1;
        tick();
        idle();
        repeat (100) tick();
        resetn = 1'b0;
        #1;
        check("mid-init reset doutb", doutb_a[0], 32'h0);
        check("mid-init reset valid", 32'(valid_a[0]), 32'd0);
        check("mid-init reset busy", 32'(busy_a[0]), 32'd1);
        tick();
        resetn = 1'b1;
        wait_init(n);
        check("restart busy cycles", n, DEPTH);
        read_lat(3, INIT_V, INIT_V);

`ifdef BLOCKMEM2P_PARITY_EN
        wr(3, 32'h1234_5678, 4'hF);
        wr(4, 32'h8765_4321, 4'hF);
        dut0.mem_par[3][1] = ~dut0.mem_par[3][1];
        bad[3] = 1'b1;
        read_lat(3, 32'h1234_5678, 32'h1234_5678);
        enb = 1'b1; addrb = 3;
        tick();
        enb = 1'b0;
        tick();
        check("perr set", 32'(perr_a[0]), 32'd1);
        read_lat(4, 32'h8765_4321, 32'h8765_4321);
        enb = 1'b1; addrb = 4;
        tick();
        enb = 1'b0;
        tick();
        check("perr clean", 32'(perr_a[0]), 32'd0);
        repeat (6) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
